// File: rtl/apb_regbank_pkg.sv
// Shared types and helpers for the APB4 register bank: FSM states,
// word-offset computation and byte-lane merging.
package apb_regbank_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  // Number of low address bits that select a byte within one data word.
  function automatic int lsb_of(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  // Replaces the byte lanes of old selected by strb with those of wdata.
  // Sized for the widest legal bus; callers extend and truncate.
  function automatic logic [63:0] byte_merge(input logic [63:0] old,
                                             input logic [63:0] wdata,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    res = old;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_regbank_decode.sv
// Combinational address decode: word index plus the error condition
// (misaligned, out of range, or write to a read-only register).
module apb_regbank_decode
  import apb_regbank_pkg::*;
#(
  parameter int                  ADDR_WIDTH = 8,
  parameter int                  DATA_WIDTH = 32,
  parameter int                  NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic                  pwrite_i,
  output logic [ADDR_WIDTH-1:0] idx_o,
  output logic                  err_o
);

  localparam int LSB = lsb_of(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << LSB) - 1);

  logic [ADDR_WIDTH-1:0] idx;
  logic                  ro;

  // Out-of-range indices never match the loop, so they read as writable.
  always_comb begin
    idx = paddr_i >> LSB;
    ro  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == ADDR_WIDTH'(i)) ro = RO_MASK[i];
    end
    idx_o = idx;
    err_o = (|(paddr_i & ALIGN_MASK)) | (32'(idx) >= NUM_REGS) | (pwrite_i & ro);
  end

endmodule

// File: rtl/apb4_slave_regbank.sv
// APB4 slave register bank with programmable wait states, byte strobes,
// error response and read-only registers backed by hardware values.
module apb4_slave_regbank
  import apb_regbank_pkg::*;
#(
  parameter int                             ADDR_WIDTH  = 8,
  parameter int                             DATA_WIDTH  = 32,
  parameter int                             NUM_REGS    = 8,
  parameter int                             WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]            RO_MASK     = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  input  logic [DATA_WIDTH/8-1:0]        PSTRB,
  output logic                           PREADY,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PSLVERR,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_rd_val,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int SW = DATA_WIDTH / 8;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  pready_q, pready_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pslverr_q, pslverr_d;
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  err_q, err_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         strb_q, strb_d;

  logic [ADDR_WIDTH-1:0] dec_idx, rsp_idx;
  logic                  dec_err, rsp_err, rsp_write;
  logic [DATA_WIDTH-1:0] rsp_data;

  apb_regbank_decode #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .RO_MASK   (RO_MASK)
  ) u_decode (
    .paddr_i (PADDR),
    .pwrite_i(PWRITE),
    .idx_o   (dec_idx),
    .err_o   (dec_err)
  );

  // With zero wait states the response is built from the live setup-phase decode.
  always_comb begin
    rsp_idx   = (state_q == IDLE) ? dec_idx : idx_q;
    rsp_err   = (state_q == IDLE) ? dec_err : err_q;
    rsp_write = (state_q == IDLE) ? PWRITE  : write_q;
    rsp_data  = '0;
    if (!rsp_write && !rsp_err) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rsp_idx == ADDR_WIDTH'(i))
          rsp_data = RO_MASK[i] ? hw_rd_val[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pready_d   = pready_q;
    prdata_d   = prdata_q;
    pslverr_d  = pslverr_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;
    idx_d      = idx_q;
    err_d      = err_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;

    case (state_q)
      IDLE: begin
        pready_d  = 1'b0;
        prdata_d  = '0;
        pslverr_d = 1'b0;
        if (PSEL && !PENABLE) begin
          idx_d   = dec_idx;
          err_d   = dec_err;
          write_d = PWRITE;
          wdata_d = PWDATA;
          strb_d  = PSTRB;
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            pready_d  = 1'b1;
            pslverr_d = rsp_err;
            prdata_d  = rsp_data;
          end
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d   = IDLE;
          cnt_d     = '0;
          pready_d  = 1'b0;
          prdata_d  = '0;
          pslverr_d = 1'b0;
        end else if (pready_q) begin
          if (PENABLE) begin
            if (write_q && !err_q && (strb_q != '0)) begin
              for (int i = 0; i < NUM_REGS; i++) begin
                if (idx_q == ADDR_WIDTH'(i)) begin
                  regs_d[i] = DATA_WIDTH'(byte_merge(64'(regs_q[i]), 64'(wdata_q), 8'(strb_q)));
                  wr_pulse_d[i] = 1'b1;
                end
              end
            end
            state_d   = IDLE;
            pready_d  = 1'b0;
            prdata_d  = '0;
            pslverr_d = 1'b0;
          end
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            pready_d  = 1'b1;
            pslverr_d = rsp_err;
            prdata_d  = rsp_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pready_q   <= 1'b0;
      prdata_q   <= '0;
      pslverr_q  <= 1'b0;
      wr_pulse_q <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      strb_q     <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pready_q   <= pready_d;
      prdata_q   <= prdata_d;
      pslverr_q  <= pslverr_d;
      wr_pulse_q <= wr_pulse_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  assign PREADY   = pready_q;
  assign PRDATA   = prdata_q;
  assign PSLVERR  = pslverr_q;
  assign wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_apb4_slave_regbank.sv
// Self-checking bench: two bank instances (0 and 3 wait states) driven by an
// APB master task, with expected responses queued at drive time.
module tb_apb4_slave_regbank;

  logic         clk = 1'b0;
  logic         rstN;
  logic         psel    [2];
  logic         penable [2];
  logic         pwrite  [2];
  logic [7:0]   paddr   [2];
  logic [31:0]  pwdata  [2];
  logic [3:0]   pstrb   [2];
  logic         pready  [2];
  logic [31:0]  prdata  [2];
  logic         pslverr [2];
  logic [255:0] regQ    [2];
  logic [255:0] hwRdVal [2];
  logic [7:0]   wrPulse [2];

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
    logic [7:0]  pulse;
  } expItem_t;

  expItem_t sbQ[$];

  always #5 clk = ~clk;

  apb4_slave_regbank #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(8), .WAIT_STATES(0), .RO_MASK(8'h80)
  ) dut0 (
    .PCLK(clk), .PRESETn(rstN), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]), .PREADY(pready[0]),
    .PRDATA(prdata[0]), .PSLVERR(pslverr[0]), .reg_q(regQ[0]), .hw_rd_val(hwRdVal[0]),
    .wr_pulse(wrPulse[0])
  );

  apb4_slave_regbank #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(8), .WAIT_STATES(3), .RO_MASK(8'h80)
  ) dut1 (
    .PCLK(clk), .PRESETn(rstN), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]), .PREADY(pready[1]),
    .PRDATA(prdata[1]), .PSLVERR(pslverr[1]), .reg_q(regQ[1]), .hw_rd_val(hwRdVal[1]),
    .wr_pulse(wrPulse[1])
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] regWord(input int d, input int i);
    logic [255:0] flat;
    flat = regQ[d];
    return flat[i*32 +: 32];
  endfunction

  // One complete APB transfer on instance d; the response is compared against
  // the scoreboard entry queued when the setup phase is driven.
  task automatic applyStimulus(input int d, input logic wr, input logic [7:0] addr,
                               input logic [31:0] data, input logic [3:0] strb,
                               input logic [31:0] expData, input logic expErr,
                               input logic [7:0] expPulse);
    expItem_t e;
    int waits;
    e.rdata = expData;
    e.err   = expErr;
    e.waits = (d == 0) ? 0 : 3;
    e.pulse = expPulse;
    sbQ.push_back(e);

    @(posedge clk); #1;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = addr; pwdata[d] = data; pstrb[d] = strb;
    @(posedge clk); #1;
    penable[d] = 1'b1;

    waits = 0;
    forever begin
      @(negedge clk);
      if (pready[d]) break;
      waits++;
      if (waits > 20) begin
        checkOutput("pready_timeout", 64'(waits), 64'(e.waits));
        break;
      end
    end

    e = sbQ.pop_front();
    checkOutput($sformatf("waits_%02h", addr), 64'(waits), 64'(e.waits));
    checkOutput($sformatf("prdata_%02h", addr), 64'(prdata[d]), 64'(e.rdata));
    checkOutput($sformatf("pslverr_%02h", addr), 64'(pslverr[d]), 64'(e.err));

    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("pready_clr_%02h", addr), 64'(pready[d]), 64'd0);
    checkOutput($sformatf("wr_pulse_%02h", addr), 64'(wrPulse[d]), 64'(e.pulse));
    @(negedge clk);
    checkOutput($sformatf("wr_pulse_end_%02h", addr), 64'(wrPulse[d]), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rstN = 1'b0;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0; hwRdVal[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_pready", 64'(pready[0]), 64'd0);
    checkOutput("rst_prdata", 64'(prdata[0]), 64'd0);
    checkOutput("rst_pslverr", 64'(pslverr[1]), 64'd0);
    checkOutput("rst_wr_pulse", 64'(wrPulse[0]), 64'd0);
    checkOutput("rst_reg_q", 64'(regQ[0] | regQ[1]), 64'd0);
    rstN = 1'b1;

    applyStimulus(0, 1'b0, 8'h04, 32'h0, 4'h0, 32'h0, 1'b0, 8'h00);

    applyStimulus(0, 1'b1, 8'h08, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 8'h04);
    applyStimulus(0, 1'b1, 8'h08, 32'h00001122, 4'b0011, 32'h0, 1'b0, 8'h04);
    checkOutput("reg2_merge", 64'(regWord(0, 2)), 64'hDEAD1122);
    applyStimulus(0, 1'b1, 8'h08, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 8'h00);
    checkOutput("reg2_nostrb", 64'(regWord(0, 2)), 64'hDEAD1122);
    applyStimulus(0, 1'b0, 8'h08, 32'h0, 4'h0, 32'hDEAD1122, 1'b0, 8'h00);

    applyStimulus(1, 1'b1, 8'h08, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 8'h04);
    applyStimulus(1, 1'b0, 8'h08, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 8'h00);

    applyStimulus(0, 1'b1, 8'h1C, 32'h11111111, 4'hF, 32'h0, 1'b1, 8'h00);
    checkOutput("reg7_ro", 64'(regWord(0, 7)), 64'h0);
    hwRdVal[0] = {32'h000055AA, 224'h0};
    applyStimulus(0, 1'b0, 8'h1C, 32'h0, 4'h0, 32'h000055AA, 1'b0, 8'h00);

    applyStimulus(0, 1'b0, 8'h20, 32'h0, 4'h0, 32'h0, 1'b1, 8'h00);
    applyStimulus(0, 1'b0, 8'h05, 32'h0, 4'h0, 32'h0, 1'b1, 8'h00);
    applyStimulus(0, 1'b1, 8'h22, 32'h12345678, 4'hF, 32'h0, 1'b1, 8'h00);

    @(posedge clk); #1;
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 8'h0C; pwdata[1] = 32'h12345678; pstrb[1] = 4'hF;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #1;
    rstN = 1'b0;
    psel[1] = 1'b0; penable[1] = 1'b0;
    #2;
    checkOutput("midrst_pready", 64'(pready[1]), 64'd0);
    checkOutput("midrst_prdata", 64'(prdata[1]), 64'd0);
    checkOutput("midrst_pslverr", 64'(pslverr[1]), 64'd0);
    checkOutput("midrst_reg2_dut0", 64'(regWord(0, 2)), 64'd0);
    checkOutput("midrst_reg2_dut1", 64'(regWord(1, 2)), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rstN = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("midrst_no_commit", 64'(regWord(1, 3)), 64'd0);
    checkOutput("midrst_no_pulse", 64'(wrPulse[1]), 64'd0);

    applyStimulus(1, 1'b1, 8'h0C, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0, 8'h08);
    checkOutput("reg3_after_rst", 64'(regWord(1, 3)), 64'hA5A5A5A5);
    applyStimulus(1, 1'b0, 8'h0C, 32'h0, 4'hF, 32'hA5A5A5A5, 1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
